mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. It computes MULT/MULTU/DIV/DIVU on two 32-bit operands and delivers the HI/LO pair with write-enables. These feed the EX→ID forwarding bus and the HI/LO register write path. It raises a stall request that freezes IF/ID/EX until the result is ready.

---
 rtl/mdu_if.sv | 27 ++
 rtl/mdu.sv | 194 +++++++++++++++++++
 tb/tb_mdu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// mdu_if: EX-stage request/response bundle for the multiply/divide unit.
// Master is the EX stage; slave is the mdu.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stallreq;
    logic             ready;
    logic             w_hi_we;
    logic             w_lo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output flush, start, op, src_a, src_b,
        input  stallreq, ready, w_hi_we, w_lo_we, hi_o, lo_o
    );

    modport slave (
        input  flush, start, op, src_a, src_b,
        output stallreq, ready, w_hi_we, w_lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO with stall and ready pulse.
// Build option MDU_MUL_ITER_EN: multiplies use the 32-cycle shift-add path instead of a 1-cycle multiply.
module mdu (
    input  logic clk,
    input  logic resetn,
    mdu_if.slave bus
);
    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [4:0]     cnt_r;
    logic [1:0]     op_r;
    logic           sa_r;
    logic           sb_r;
    logic [W-1:0]   b_mag_r;
    logic [W-1:0]   a_raw_r;
    logic [W-1:0]   work_hi_r;
    logic [W-1:0]   work_lo_r;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;
    logic           ready_r;

    logic           sa_in_s;
    logic           sb_in_s;
    logic [W-1:0]   a_mag_in_s;
    logic [W-1:0]   b_mag_in_s;
    logic [W:0]     shifted_s;
    logic           ge_s;
    logic [W-1:0]   diff_s;
    logic [W-1:0]   next_hi_s;
    logic [W-1:0]   next_lo_s;
    logic [2*W-1:0] iter_res_s;
`ifdef MDU_MUL_ITER_EN
    logic [W-1:0]   a_mag_r;
    logic [W:0]     sum_s;
`else
    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] fast_res_s;
`endif

    // Turns magnitude results into signed HI/LO, including the divide-by-zero pattern.
    function automatic logic [2*W-1:0] finish_result(
        input logic         is_div,
        input logic         sa,
        input logic         sb,
        input logic [W-1:0] a_raw,
        input logic [W-1:0] b_mag,
        input logic [W-1:0] mag_hi,
        input logic [W-1:0] mag_lo
    );
        logic [2*W-1:0] res;
        logic [2*W-1:0] prod;
        prod = {mag_hi, mag_lo};
        if (is_div) begin
            if (b_mag == 32'd0) begin
                res = {a_raw, 32'hFFFF_FFFF};
            end else begin
                res = {sa ? (32'd0 - mag_hi) : mag_hi,
                       (sa ^ sb) ? (32'd0 - mag_lo) : mag_lo};
            end
        end else begin
            res = (sa ^ sb) ? (64'd0 - prod) : prod;
        end
        return res;
    endfunction

    // Operand sign/magnitude split; only MULT and DIV (op[0]==0) are signed.
    always_comb begin
        sa_in_s    = ~bus.op[0] & bus.src_a[W-1];
        sb_in_s    = ~bus.op[0] & bus.src_b[W-1];
        a_mag_in_s = sa_in_s ? (32'd0 - bus.src_a) : bus.src_a;
        b_mag_in_s = sb_in_s ? (32'd0 - bus.src_b) : bus.src_b;
    end

    // One radix-2 step: restoring divide (hi=remainder, lo=quotient) or shift-add multiply.
    always_comb begin
        shifted_s = {work_hi_r, work_lo_r[W-1]};
        ge_s      = (shifted_s >= {1'b0, b_mag_r});
        diff_s    = shifted_s[W-1:0] - b_mag_r;
`ifdef MDU_MUL_ITER_EN
        sum_s     = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, a_mag_r} : 33'd0);
`endif
        if (op_r[1]) begin
            next_hi_s = ge_s ? diff_s : shifted_s[W-1:0];
            next_lo_s = {work_lo_r[W-2:0], ge_s};
        end else begin
`ifdef MDU_MUL_ITER_EN
            next_hi_s = sum_s[W:1];
            next_lo_s = {sum_s[0], work_lo_r[W-1:1]};
`else
            next_hi_s = work_hi_r;
            next_lo_s = work_lo_r;
`endif
        end
        iter_res_s = finish_result(op_r[1], sa_r, sb_r, a_raw_r, b_mag_r, next_hi_s, next_lo_s);
    end

`ifdef MDU_MUL_ITER_EN
`else
    // Single-cycle multiply straight from the operand bus.
    always_comb begin
        prod_s     = {32'd0, a_mag_in_s} * {32'd0, b_mag_in_s};
        fast_res_s = finish_result(1'b0, sa_in_s, sb_in_s, bus.src_a, b_mag_in_s,
                                   prod_s[2*W-1:W], prod_s[W-1:0]);
    end
`endif

    // Results are registered on entry to DONE so hi/lo are valid while ready is high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            op_r      <= 2'd0;
            sa_r      <= 1'b0;
            sb_r      <= 1'b0;
            b_mag_r   <= 32'd0;
            a_raw_r   <= 32'd0;
            work_hi_r <= 32'd0;
            work_lo_r <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            ready_r   <= 1'b0;
`ifdef MDU_MUL_ITER_EN
            a_mag_r   <= 32'd0;
`endif
        end else if (bus.flush) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.start) begin
                        op_r      <= bus.op;
                        sa_r      <= sa_in_s;
                        sb_r      <= sb_in_s;
                        b_mag_r   <= b_mag_in_s;
                        a_raw_r   <= bus.src_a;
                        cnt_r     <= 5'd0;
                        work_hi_r <= 32'd0;
                        work_lo_r <= bus.op[1] ? a_mag_in_s : b_mag_in_s;
`ifdef MDU_MUL_ITER_EN
                        a_mag_r   <= a_mag_in_s;
                        state_r   <= BUSY;
`else
                        if (bus.op[1]) begin
                            state_r <= BUSY;
                        end else begin
                            state_r <= DONE;
                            hi_r    <= fast_res_s[2*W-1:W];
                            lo_r    <= fast_res_s[W-1:0];
                            ready_r <= 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    work_hi_r <= next_hi_s;
                    work_lo_r <= next_lo_s;
                    cnt_r     <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= DONE;
                        hi_r    <= iter_res_s[2*W-1:W];
                        lo_r    <= iter_res_s[W-1:0];
                        ready_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // The stall covers the accept cycle so EX holds the instruction until DONE.
    assign bus.stallreq = resetn & (((state_r == IDLE) & bus.start & ~bus.flush) | (state_r == BUSY));
    assign bus.ready    = ready_r;
    assign bus.w_hi_we  = ready_r;
    assign bus.w_lo_we  = ready_r;
    assign bus.hi_o     = hi_r;
    assign bus.lo_o     = lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors for mdu, with a cycle-level reference model compared every cycle.
module tb_mdu;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    mdu_if #(.WIDTH(32)) bus ();
    mdu dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    always #5 clk = ~clk;

`ifdef MDU_MUL_ITER_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 1;
`endif
    localparam int DIV_LAT = 33;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'd0: res = 64'(sa * sb);
            2'd1: res = ua * ub;
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return res;
    endfunction

    // Reference model: an accepted op yields its result after a fixed latency.
    logic        m_active = 1'b0;
    logic        m_ready  = 1'b0;
    int          m_left   = 0;
    int          m_lat    = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic [63:0] m_res;
    logic        exp_stall;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 1'b0; m_ready = 1'b0; m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (bus.flush) begin
            m_active = 1'b0; m_ready = 1'b0;
        end else if (m_ready) begin
            m_ready = 1'b0;
        end else if (m_active) begin
            m_left--;
            if (m_left == 0) begin
                m_active = 1'b0; m_ready = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
        end else if (bus.start) begin
            m_res = ref_result(bus.op, bus.src_a, bus.src_b);
            m_lat = bus.op[1] ? DIV_LAT : MUL_LAT;
            if (m_lat == 1) begin
                m_ready = 1'b1; m_hi = m_res[63:32]; m_lo = m_res[31:0];
            end else begin
                m_active = 1'b1; m_left = m_lat - 1; p_hi = m_res[63:32]; p_lo = m_res[31:0];
            end
        end
    end

    always @(negedge clk) begin
        exp_stall = resetn && ((!m_active && !m_ready && bus.start && !bus.flush) || m_active);
        check("cyc_stallreq", bus.stallreq, exp_stall);
        check("cyc_ready",    bus.ready,    m_ready);
        check("cyc_w_hi_we",  bus.w_hi_we,  m_ready);
        check("cyc_w_lo_we",  bus.w_lo_we,  m_ready);
        check("cyc_hi_o",     bus.hi_o,     m_hi);
        check("cyc_lo_o",     bus.lo_o,     m_lo);
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] eh, input logic [31:0] el);
        int cyc    = 0;
        int stalls = 0;
        bit got    = 1'b0;
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (bus.stallreq) stalls++;
            if (bus.ready) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({name, "_ready_seen"}, got, 1);
        check({name, "_latency"}, cyc, lat);
        check({name, "_stall_cycles"}, stalls, lat);
        check({name, "_hi"}, bus.hi_o, eh);
        check({name, "_lo"}, bus.lo_o, el);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0; bus.start = 1'b0; bus.op = 2'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", bus.hi_o, 0);
        check("reset_lo", bus.lo_o, 0);
        check("reset_ready", bus.ready, 0);
        check("reset_stallreq", bus.stallreq, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7",   2'd3, 32'd100,         32'd7,           DIV_LAT, 32'd2,           32'd14);
        run_op("div_m7_2",     2'd2, 32'hFFFF_FFF9,   32'd2,           DIV_LAT, 32'hFFFF_FFFF,   32'hFFFF_FFFD);
        run_op("div_min_m1",   2'd2, 32'h8000_0000,   32'hFFFF_FFFF,   DIV_LAT, 32'd0,           32'h8000_0000);
        run_op("divu_5_0",     2'd3, 32'd5,           32'd0,           DIV_LAT, 32'd5,           32'hFFFF_FFFF);
        run_op("div_m8_0",     2'd2, 32'hFFFF_FFF8,   32'd0,           DIV_LAT, 32'hFFFF_FFF8,   32'hFFFF_FFFF);
        run_op("div_7_m2",     2'd2, 32'd7,           32'hFFFF_FFFE,   DIV_LAT, 32'd1,           32'hFFFF_FFFD);
        run_op("divu_max_1",   2'd3, 32'hFFFF_FFFF,   32'd1,           DIV_LAT, 32'd0,           32'hFFFF_FFFF);
        run_op("mult_m1_2",    2'd0, 32'hFFFF_FFFF,   32'd2,           MUL_LAT, 32'hFFFF_FFFF,   32'hFFFF_FFFE);
        run_op("multu_max_2",  2'd1, 32'hFFFF_FFFF,   32'd2,           MUL_LAT, 32'd1,           32'hFFFF_FFFE);
        run_op("mult_min_min", 2'd0, 32'h8000_0000,   32'h8000_0000,   MUL_LAT, 32'h4000_0000,   32'd0);
        run_op("divu_prior",   2'd3, 32'd100,         32'd7,           DIV_LAT, 32'd2,           32'd14);

        // Flush at the tenth BUSY cycle of a divide.
        bus.start = 1'b1; bus.op = 2'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("flush_stallreq", bus.stallreq, 0);
        check("flush_ready", bus.ready, 0);
        check("flush_hi_kept", bus.hi_o, 32'd2);
        check("flush_lo_kept", bus.lo_o, 32'd14);
        @(posedge clk); #1;
        run_op("after_flush",  2'd1, 32'd6,           32'd7,           MUL_LAT, 32'd0,           32'd42);

        // Asynchronous reset in the middle of a divide.
        bus.start = 1'b1; bus.op = 2'd3; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_stallreq", bus.stallreq, 0);
        check("async_rst_ready", bus.ready, 0);
        check("async_rst_hi", bus.hi_o, 0);
        check("async_rst_lo", bus.lo_o, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_op("multu_3_4",    2'd1, 32'd3,           32'd4,           MUL_LAT, 32'd0,           32'd12);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
